// File: rtl/lms_pkg.sv
// lms_pkg: shared constants, FSM state type and saturation helper for the LMS filter stages.
package lms_pkg;
    localparam int NUM_TAPS = 8;
    localparam int DATA_W   = 16;
    localparam int FRAC_W   = 8;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    // Clamp a signed value into the signed range of a w-bit word; caller truncates to w bits.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction
endpackage

// File: rtl/lms_error_stage_if.sv
// lms_error_stage_if: sample input, coefficient feedback and tap/error output bundle of the error stage.
interface lms_error_stage_if #(parameter int BIT_WIDTH = lms_pkg::DATA_W);
    import lms_pkg::*;
    logic signed [BIT_WIDTH-1:0] sample_in;
    logic signed [BIT_WIDTH-1:0] desired_in;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [BIT_WIDTH-1:0] coeff [NUM_TAPS];
    logic signed [BIT_WIDTH-1:0] x [NUM_TAPS];
    logic signed [BIT_WIDTH-1:0] y_out;
    logic signed [BIT_WIDTH-1:0] error_out;
    logic                        out_valid;

    modport master (output sample_in, desired_in, in_valid, coeff,
                    input  in_ready, x, y_out, error_out, out_valid);
    modport slave  (input  sample_in, desired_in, in_valid, coeff,
                    output in_ready, x, y_out, error_out, out_valid);
endinterface

// File: rtl/lms_tap_line.sv
// lms_tap_line: DEPTH-deep signed delay line, taps[0] newest, shifting only when shift_en is high.
module lms_tap_line #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    shift_en,
    input  logic signed [WIDTH-1:0] din,
    output logic signed [WIDTH-1:0] taps [DEPTH]
);
    logic signed [WIDTH-1:0] taps_q [DEPTH];
    logic signed [WIDTH-1:0] taps_d [DEPTH];

    always_comb begin
        taps_d = taps_q;
        if (shift_en) begin
            taps_d[0] = din;
            for (int k = 1; k < DEPTH; k++) taps_d[k] = taps_q[k-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) taps_q <= '{default: '0};
        else        taps_q <= taps_d;
    end

    assign taps = taps_q;
endmodule

// File: rtl/lms_error_stage.sv
// lms_error_stage: 8-tap FIR with one time-shared multiplier, producing y and error = desired - y
// for the downstream LMS coefficient update.
module lms_error_stage
    import lms_pkg::*;
#(
    parameter int BIT_WIDTH = DATA_W,
    parameter int FRAC_BITS = FRAC_W
) (
    input logic               clk,
    input logic               rst_n,
    lms_error_stage_if.slave  bus
);
    localparam int AW = 2 * BIT_WIDTH + 3;
    typedef logic signed [BIT_WIDTH-1:0] word_t;

    state_t                  state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    word_t                   coeff_q [NUM_TAPS];
    word_t                   coeff_d [NUM_TAPS];
    word_t                   desired_q, desired_d;
    word_t                   y_q, y_d;
    word_t                   err_q, err_d;
    logic                    out_valid_q, out_valid_d;
    word_t                   taps [NUM_TAPS];
    logic                    accept;
    logic signed [2*BIT_WIDTH-1:0] prod;
    logic signed [AW-1:0]    shifted;
    logic signed [BIT_WIDTH:0] diff;
    word_t                   y_sat, err_sat;

    assign accept = (state_q == IDLE) && bus.in_valid;

    lms_tap_line #(.WIDTH(BIT_WIDTH), .DEPTH(NUM_TAPS)) u_taps (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (accept),
        .din      (bus.sample_in),
        .taps     (taps)
    );

    assign prod    = (2*BIT_WIDTH)'(coeff_q[idx_q]) * (2*BIT_WIDTH)'(taps[idx_q]);
    assign shifted = acc_q >>> FRAC_BITS;
    assign y_sat   = BIT_WIDTH'(saturate(64'(shifted), BIT_WIDTH));
    assign diff    = (BIT_WIDTH+1)'(desired_q) - (BIT_WIDTH+1)'(y_sat);
    assign err_sat = BIT_WIDTH'(saturate(64'(diff), BIT_WIDTH));

    // OUT is the settle cycle after the last MAC; results are registered on its exit edge,
    // so the pulse overlaps the first IDLE cycle and back-to-back samples run every 10 cycles.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        coeff_d     = coeff_q;
        desired_d   = desired_q;
        y_d         = y_q;
        err_d       = '0;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                state_d   = MAC;
                idx_d     = '0;
                acc_d     = '0;
                coeff_d   = bus.coeff;
                desired_d = bus.desired_in;
            end
            MAC: begin
                acc_d   = acc_q + AW'(prod);
                idx_d   = idx_q + 3'd1;
                state_d = (idx_q == 3'd7) ? OUT : MAC;
            end
            OUT: begin
                y_d         = y_sat;
                err_d       = err_sat;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            coeff_q     <= '{default: '0};
            desired_q   <= '0;
            y_q         <= '0;
            err_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            coeff_q     <= coeff_d;
            desired_q   <= desired_d;
            y_q         <= y_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.x         = taps;
    assign bus.y_out     = y_q;
    assign bus.error_out = err_q;
    assign bus.out_valid = out_valid_q;
endmodule
